// File: rtl/div_init_module.sv
// rtl/div_init_module.sv - divider input stage: sign/magnitude split and packing of the first shifter word (option: DIV_ZERO_DETECT_EN)
module div_init_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] temp_out,
    output logic [9:0]  item_out,
    output logic [3:0]  out_tag,
    output logic        out_dz
);

    logic       r_s1_valid;
    logic [7:0] r_s1_dividend;
    logic [7:0] r_s1_divisor;
    logic [3:0] r_s1_tag;
    logic [3:0] r_tag_cnt;

    logic        r_s2_valid;
    logic [15:0] r_s2_temp;
    logic [9:0]  r_s2_item;
    logic [3:0]  r_s2_tag;

    logic       w_en;
    logic       w_xfer;
    logic [7:0] w_dividend_mag;
    logic [7:0] w_divisor_mag;

    // Both stages move in lockstep; an empty S1 still occupies a slot.
    assign w_en     = !r_s2_valid || out_ready;
    assign w_xfer   = in_valid && w_en;
    assign in_ready = w_en;

    // -128 negates to itself, which reads correctly as unsigned 8'h80.
    assign w_dividend_mag = r_s1_dividend[7] ? (~r_s1_dividend + 8'd1) : r_s1_dividend;
    assign w_divisor_mag  = r_s1_divisor[7]  ? (~r_s1_divisor  + 8'd1) : r_s1_divisor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_dividend <= 8'h00;
            r_s1_divisor  <= 8'h00;
            r_s1_tag      <= 4'h0;
            r_tag_cnt     <= 4'h0;
        end else begin
            if (w_en) begin
                r_s1_valid <= w_xfer;
            end
            if (w_xfer) begin
                r_s1_dividend <= dividend;
                r_s1_divisor  <= divisor;
                r_s1_tag      <= r_tag_cnt;
                r_tag_cnt     <= r_tag_cnt + 4'd1;
            end
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic r_s1_dz;
    logic r_s2_dz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_dz <= 1'b0;
            r_s2_dz <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_s1_dz <= (divisor == 8'h00);
            end
            if (w_en) begin
                r_s2_dz <= r_s1_dz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_temp  <= 16'h0000;
            r_s2_item  <= 10'h000;
            r_s2_tag   <= 4'h0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_temp  <= r_s1_dz ? 16'h0000 : {8'h00, w_dividend_mag};
            r_s2_item  <= {w_divisor_mag, r_s1_dividend[7], r_s1_divisor[7]};
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign out_dz = r_s2_dz;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_temp  <= 16'h0000;
            r_s2_item  <= 10'h000;
            r_s2_tag   <= 4'h0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_temp  <= {8'h00, w_dividend_mag};
            r_s2_item  <= {w_divisor_mag, r_s1_dividend[7], r_s1_divisor[7]};
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign out_dz = 1'b0;
`endif

    assign out_valid = r_s2_valid;
    assign temp_out  = r_s2_temp;
    assign item_out  = r_s2_item;
    assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_div_init_module.sv
// tb/tb_div_init_module.sv - scoreboard bench for div_init_module (honours DIV_ZERO_DETECT_EN)
module tb_div_init_module;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  dividend = 8'h00;
    logic [7:0]  divisor = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] temp_out;
    logic [9:0]  item_out;
    logic [3:0]  out_tag;
    logic        out_dz;

    div_init_module dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .temp_out(temp_out), .item_out(item_out),
        .out_tag(out_tag), .out_dz(out_dz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] temp;
        logic [9:0]  item;
        logic [3:0]  tag;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_emit = 0;
    int   model_tag = 0;
    logic [3:0] last_tag = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: signed values as integers, magnitudes via plain absolute value.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int tag);
        exp_t e;
        int sa;
        int sb;
        int ma;
        int mb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        e.temp = 16'(ma);
        e.item = {8'(mb), (sa < 0), (sb < 0)};
        e.tag  = 4'(tag);
        e.dz   = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        if (sb == 0) begin
            e.dz   = 1'b1;
            e.temp = 16'h0000;
        end
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_tag = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_temp", 32'(temp_out), 32'(e.temp));
                    chk("sb_item", 32'(item_out), 32'(e.item));
                    chk("sb_tag",  32'(out_tag),  32'(e.tag));
                    chk("sb_dz",   32'(out_dz),   32'(e.dz));
                end
                last_tag = out_tag;
                n_emit++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(dividend, divisor, model_tag));
                model_tag = (model_tag + 1) % 16;
            end
        end
    end

    // Entered and left at posedge+1; holds in_valid until the op is taken.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        logic acc;
        int   guard;
        guard = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        dividend = a;
        divisor = b;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [15:0] t, input logic [9:0] it,
                            input logic [3:0] tg, input logic dz);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_temp"}, 32'(temp_out), 32'(t));
        chk({nm, "_item"}, 32'(item_out), 32'(it));
        chk({nm, "_tag"},  32'(out_tag),  32'(tg));
        chk({nm, "_dz"},   32'(out_dz),   32'(dz));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e0;
        logic [15:0] snap_temp;
        logic [9:0]  snap_item;
        logic [3:0]  snap_tag;
        int          emit0;
        bit          done;

        // Reset state
        @(negedge clk);
        chk("in_ready_during_reset", 32'(in_ready), 32'd1);
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_temp", 32'(temp_out), 32'h0);
        chk("rst_item", 32'(item_out), 32'h0);
        chk("rst_tag", 32'(out_tag), 32'h0);
        chk("rst_dz", 32'(out_dz), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 100 / 7
        send(8'd100, 8'd7);
        wait_out("op_100_7", 16'h0064, 10'h01C, 4'h0, 1'b0);
        @(posedge clk);
        #1;

        // -100 / 7 and -128 / -1 back to back
        do_reset();
        send(8'h9C, 8'd7);
        send(8'h80, 8'hFF);
        wait_out("op_m100_7", 16'h0064, 10'h01E, 4'h0, 1'b0);
        @(negedge clk);
        chk("op_m128_m1_valid", 32'(out_valid), 32'd1);
        chk("op_m128_m1_temp", 32'(temp_out), 32'h0080);
        chk("op_m128_m1_item", 32'(item_out), 32'h007);
        chk("op_m128_m1_tag", 32'(out_tag), 32'h1);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: op0 held in S2, op1 held in S1, op2 waits
        do_reset();
        emit0 = n_emit;
        out_ready = 1'b0;
        e0 = model(8'hD3, 8'h05, 0);
        send(8'hD3, 8'h05);
        send(8'($urandom), 8'($urandom));
        in_valid = 1'b1;
        @(negedge clk);
        snap_temp = temp_out;
        snap_item = item_out;
        snap_tag = out_tag;
        chk("stall_head_temp", 32'(snap_temp), 32'(e0.temp));
        chk("stall_head_item", 32'(snap_item), 32'(e0.item));
        chk("stall_head_tag", 32'(snap_tag), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dividend = 8'($urandom);
            divisor = 8'($urandom);
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", {6'd0, snap_tag, snap_item, snap_temp}[31:0],
                {6'd0, out_tag, item_out, temp_out}[31:0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'($urandom), 8'($urandom));
        drain();
        chk("stall_emit_count", 32'(n_emit - emit0), 32'd3);

        // 17 ops: tag wraps 15 -> 0
        do_reset();
        for (int i = 0; i < 17; i++) send(8'($urandom), 8'($urandom));
        drain();
        chk("wrap_last_tag", 32'(last_tag), 32'h0);

        // Reset with two ops in flight
        send(8'd20, 8'd3);
        send(8'd21, 8'd4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(8'd50, 8'hF6);
        wait_out("post_rst", 16'h0032, 10'h029, 4'h0, 1'b0);
        @(posedge clk);
        #1;

        // 5 / 0
        do_reset();
        send(8'd5, 8'd0);
`ifdef DIV_ZERO_DETECT_EN
        wait_out("div_zero", 16'h0000, 10'h000, 4'h0, 1'b1);
`else
        wait_out("div_zero", 16'h0005, 10'h000, 4'h0, 1'b0);
`endif
        @(posedge clk);
        #1;
        drain();

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
                end
                done = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
